// File: rtl/mem_arb_pkg.sv
// Shared types, size codes and helpers for the external RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IFETCH,
        ST_LOAD,
        ST_STORE,
        ST_DONE
    } arb_state_e;

    // lsu_size codes; 2'd2 and 2'd3 both mean a full word
    localparam logic [1:0] LSU_SIZE_BYTE = 2'd0;
    localparam logic [1:0] LSU_SIZE_HALF = 2'd1;

    localparam logic [1:0]  IO_ADDR_HI_DEFAULT = 2'b11;
    localparam int unsigned CNT_W              = 7;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            LSU_SIZE_BYTE: return 3'd1;
            LSU_SIZE_HALF: return 3'd2;
            default:       return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester, control and RAM-pin signals of the memory arbiter.
interface memory_arbiter_if;
    logic        rdy_in;
    logic        flush_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        ic_en;
    logic [31:0] ic_addr;
    logic [7:0]  ic_byte;
    logic        ic_valid;
    logic        ic_done;
    logic        lsu_en;
    logic        lsu_wr;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;

    modport slave (
        input  rdy_in, flush_in, mem_din, io_buffer_full,
        input  ic_en, ic_addr, lsu_en, lsu_wr, lsu_addr, lsu_size, lsu_wdata,
        output mem_dout, mem_a, mem_wr, ic_byte, ic_valid, ic_done, lsu_rdata, lsu_done
    );

    modport master (
        output rdy_in, flush_in, mem_din, io_buffer_full,
        output ic_en, ic_addr, lsu_en, lsu_wr, lsu_addr, lsu_size, lsu_wdata,
        input  mem_dout, mem_a, mem_wr, ic_byte, ic_valid, ic_done, lsu_rdata, lsu_done
    );
endinterface

// File: rtl/mem_byte_sequencer.sv
// Byte counter and base+k address generator, reloaded at every grant.
module mem_byte_sequencer
    import mem_arb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [31:0]      i_base,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_cnt,
    output logic [31:0]      o_addr,
    output logic             o_last
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic [31:0]      r_base;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_base <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_cnt  <= '0;
                r_len  <= i_len;
                r_base <= i_base;
            end else if (i_adv) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_addr = r_base + 32'(r_cnt);
    assign o_last = (r_cnt == r_len - CNT_W'(1));
endmodule

// File: rtl/memory_arbiter.sv
// Single-owner sequencer for the byte-wide RAM port (icache fill vs LSU).
// Optional MEM_ARB_IO_STALL_EN: stall IO-range store bytes while io_buffer_full.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned IFETCH_BYTES = 4,
    parameter logic [1:0]  IO_ADDR_HI   = IO_ADDR_HI_DEFAULT
)(
    input logic              clk_in,
    input logic              rst_in,
    memory_arbiter_if.slave  bus
);
    // Reads take one extra cycle so the last byte's data can be captured
    localparam logic [CNT_W-1:0] IFETCH_LEN = CNT_W'(IFETCH_BYTES + 1);

    arb_state_e       r_state, w_state_next;
    logic             r_last_grant_lsu;
    logic [31:0]      r_wdata, r_acc;
    logic             w_grant_lsu, w_grant_ic, w_load, w_adv, w_stall, w_io_hit, w_capture, w_last;
    logic [2:0]       w_lsu_n;
    logic [CNT_W-1:0] w_cnt, w_len;
    logic [31:0]      w_base, w_seq_addr, w_acc_next;
    logic [1:0]       w_idx;

    assign w_grant_lsu = (r_state == ST_IDLE) && bus.lsu_en && (!bus.ic_en || !r_last_grant_lsu);
    assign w_grant_ic  = (r_state == ST_IDLE) && bus.ic_en && !w_grant_lsu;
    assign w_load      = w_grant_lsu || w_grant_ic;
    assign w_lsu_n     = size_to_bytes(bus.lsu_size);
    assign w_base      = w_grant_lsu ? bus.lsu_addr : bus.ic_addr;
    assign w_len       = w_grant_lsu ? (CNT_W'(w_lsu_n) + (bus.lsu_wr ? CNT_W'(0) : CNT_W'(1)))
                                     : IFETCH_LEN;

    mem_byte_sequencer u_seq (
        .i_clk  (clk_in),
        .i_rst  (rst_in),
        .i_en   (bus.rdy_in),
        .i_load (w_load),
        .i_base (w_base),
        .i_len  (w_len),
        .i_adv  (w_adv),
        .o_cnt  (w_cnt),
        .o_addr (w_seq_addr),
        .o_last (w_last)
    );

    assign w_io_hit = (w_seq_addr[17:16] == IO_ADDR_HI);
`ifdef MEM_ARB_IO_STALL_EN
    assign w_stall = (r_state == ST_STORE) && w_io_hit && bus.io_buffer_full;
`else
    logic w_unused_stall;
    assign w_unused_stall = w_io_hit ^ bus.io_buffer_full;
    assign w_stall        = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)          r_state <= ST_IDLE;
        else if (bus.rdy_in) r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_lsu)     w_state_next = bus.lsu_wr ? ST_STORE : ST_LOAD;
                else if (w_grant_ic) w_state_next = ST_IFETCH;
            end
            ST_IFETCH, ST_LOAD: begin
                if (bus.flush_in) w_state_next = ST_IDLE;
                else if (w_last)  w_state_next = ST_DONE;
            end
            ST_STORE: if (w_last && !w_stall) w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // RAM pins and sequencing strobes; byte k's data arrives while the counter reads k+1
    always_comb begin
        bus.mem_a    = '0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = '0;
        w_adv        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IFETCH, ST_LOAD: begin
                bus.mem_a = w_last ? '0 : w_seq_addr;
                w_adv     = 1'b1;
                w_capture = (w_cnt != '0) && !bus.flush_in;
            end
            ST_STORE: begin
                bus.mem_a    = w_seq_addr;
                bus.mem_wr   = bus.rdy_in && !w_stall;
                bus.mem_dout = 8'(r_wdata >> {w_cnt[1:0], 3'b000});
                w_adv        = !w_stall;
            end
            default: ;
        endcase
    end

    assign w_idx      = 2'(w_cnt - CNT_W'(1));
    assign w_acc_next = r_acc | (32'(bus.mem_din) << {w_idx, 3'b000});

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_last_grant_lsu <= 1'b0;
            r_wdata          <= '0;
            r_acc            <= '0;
            bus.ic_byte      <= '0;
            bus.ic_valid     <= 1'b0;
            bus.ic_done      <= 1'b0;
            bus.lsu_rdata    <= '0;
            bus.lsu_done     <= 1'b0;
        end else if (bus.rdy_in) begin
            bus.ic_valid <= 1'b0;
            bus.ic_done  <= 1'b0;
            bus.lsu_done <= 1'b0;
            if (w_load) begin
                r_last_grant_lsu <= w_grant_lsu;
                r_acc            <= '0;
            end
            if (w_grant_lsu) r_wdata <= bus.lsu_wdata;
            if (w_capture && r_state == ST_IFETCH) begin
                bus.ic_byte  <= bus.mem_din;
                bus.ic_valid <= 1'b1;
                bus.ic_done  <= w_last;
            end
            if (w_capture && r_state == ST_LOAD) begin
                r_acc <= w_acc_next;
                if (w_last) begin
                    bus.lsu_rdata <= w_acc_next;
                    bus.lsu_done  <= 1'b1;
                end
            end
            if (r_state == ST_STORE && w_last && !w_stall) bus.lsu_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter; inputs driven 1 after posedge, outputs checked 4 after.
module tb_memory_arbiter;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    memory_arbiter_if bus();

    memory_arbiter dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h11;
            32'h1001: return 8'h22;
            32'h1002: return 8'h33;
            32'h1003: return 8'h44;
            default:  return a[7:0] + 8'h5A;
        endcase
    endfunction

    // RAM with one-cycle read latency
    always @(posedge clk_in) bus.mem_din <= ram_rd(bus.mem_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic go();
        @(posedge clk_in);
        #1;
    endtask

    logic        win_lsu;
    int          n, k, st_done, vcnt, dcnt;
    logic [7:0]  st_wr;
    logic [31:0] wd;

    initial begin
        bus.rdy_in = 1'b1; bus.flush_in = 1'b0; bus.io_buffer_full = 1'b0;
        bus.ic_en = 1'b0; bus.ic_addr = '0;
        bus.lsu_en = 1'b0; bus.lsu_wr = 1'b0; bus.lsu_addr = '0; bus.lsu_size = '0; bus.lsu_wdata = '0;

        // reset values
        #1 rst_in = 1'b1;
        #3;
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk1("rst_mem_wr", bus.mem_wr, 1'b0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst_ic_byte", 32'(bus.ic_byte), 32'h0);
        chk1("rst_ic_valid", bus.ic_valid, 1'b0);
        chk1("rst_ic_done", bus.ic_done, 1'b0);
        chk("rst_lsu_rdata", bus.lsu_rdata, 32'h0);
        chk1("rst_lsu_done", bus.lsu_done, 1'b0);
        go(); rst_in = 1'b0;

        // simultaneous requests alternate LSU, IC, LSU
        for (int r = 0; r < 3; r++) begin
            win_lsu = (r != 1);
            go();
            bus.ic_en = 1'b1; bus.ic_addr = 32'h2000;
            bus.lsu_en = 1'b1; bus.lsu_wr = 1'b0; bus.lsu_size = 2'd0; bus.lsu_addr = 32'h1000;
            go(); #3;
            chk("tie_grant", bus.mem_a, win_lsu ? 32'h1000 : 32'h2000);
            if (win_lsu) bus.ic_en = 1'b0; else bus.lsu_en = 1'b0;
            n = win_lsu ? 2 : 5;
            repeat (n) go();
            #3;
            if (win_lsu) begin
                chk1("tie_lsu_done", bus.lsu_done, 1'b1);
                chk("tie_lsu_rdata", bus.lsu_rdata, 32'h0000_0011);
            end else begin
                chk1("tie_ic_done", bus.ic_done, 1'b1);
                chk("tie_ic_byte", 32'(bus.ic_byte), 32'h5D);
            end
            bus.ic_en = 1'b0; bus.lsu_en = 1'b0;
        end

        // load word from 0x1000; request inputs change after grant
        go();
        bus.lsu_en = 1'b1; bus.lsu_wr = 1'b0; bus.lsu_size = 2'd2; bus.lsu_addr = 32'h1000;
        go(); #3;
        chk("ld_a0", bus.mem_a, 32'h1000);
        bus.lsu_addr = 32'hDEAD_0000; bus.lsu_size = 2'd0;
        go(); #3;
        chk("ld_a1", bus.mem_a, 32'h1001);
        repeat (3) go();
        #3;
        chk1("ld_done_g4", bus.lsu_done, 1'b0);
        go(); #3;
        chk1("ld_done_g5", bus.lsu_done, 1'b1);
        chk("ld_rdata", bus.lsu_rdata, 32'h4433_2211);
        chk("ld_done_mem_a", bus.mem_a, 32'h0);
        bus.lsu_en = 1'b0;
        go(); #3;
        chk1("ld_done_pulse", bus.lsu_done, 1'b0);
        chk("ld_rdata_hold", bus.lsu_rdata, 32'h4433_2211);

        // icache fill of 4 bytes at 0x2000
        go();
        bus.ic_en = 1'b1; bus.ic_addr = 32'h2000;
        for (int j = 0; j < 7; j++) begin
            go(); #3;
            chk1("if_valid", bus.ic_valid, (j >= 2 && j <= 5));
            chk1("if_done", bus.ic_done, (j == 5));
            if (j >= 2 && j <= 5) chk("if_byte", 32'(bus.ic_byte), 32'h5A + 32'(j - 2));
            if (j == 5) bus.ic_en = 1'b0;
        end

        // flush during a fill
        go();
        bus.ic_en = 1'b1; bus.ic_addr = 32'h2000;
        go(); go(); go(); #3;
        chk1("fl_v0", bus.ic_valid, 1'b1);
        chk("fl_b0", 32'(bus.ic_byte), 32'h5A);
        vcnt = 1; dcnt = 0;
        bus.flush_in = 1'b1; bus.ic_en = 1'b0;
        go(); bus.flush_in = 1'b0; #3;
        chk("fl_idle_mem_a", bus.mem_a, 32'h0);
        vcnt += int'(bus.ic_valid); dcnt += int'(bus.ic_done);
        repeat (3) begin
            go(); #3;
            vcnt += int'(bus.ic_valid); dcnt += int'(bus.ic_done);
        end
        chk1("fl_vcount", (vcnt <= 2), 1'b1);
        chk("fl_no_done", 32'(dcnt), 32'h0);

        // store word 0xDEADBEEF to 0x30000 with io_buffer_full high in G+1..G+3
`ifdef MEM_ARB_IO_STALL_EN
        st_wr = 8'b0111_0001; st_done = 7;
`else
        st_wr = 8'b0000_1111; st_done = 4;
`endif
        wd = 32'hDEAD_BEEF; k = 0;
        go();
        bus.lsu_en = 1'b1; bus.lsu_wr = 1'b1; bus.lsu_size = 2'd2;
        bus.lsu_addr = 32'h0003_0000; bus.lsu_wdata = wd;
        for (int j = 0; j <= st_done; j++) begin
            go();
            bus.io_buffer_full = (j >= 1 && j <= 3);
            #3;
            if (j < st_done) begin
                chk1("st_wr", bus.mem_wr, st_wr[j]);
                chk1("st_done_early", bus.lsu_done, 1'b0);
                if (st_wr[j]) begin
                    chk("st_dout", 32'(bus.mem_dout), 32'(8'(wd >> (8 * k))));
                    chk("st_a", bus.mem_a, 32'h0003_0000 + 32'(k));
                    k++;
                end
            end else begin
                chk1("st_done", bus.lsu_done, 1'b1);
                chk1("st_done_wr", bus.mem_wr, 1'b0);
                bus.lsu_en = 1'b0;
            end
        end
        bus.io_buffer_full = 1'b0;

        // store halfword across the address wrap, with flush and rdy low mid-store
        go();
        bus.lsu_en = 1'b1; bus.lsu_wr = 1'b1; bus.lsu_size = 2'd1;
        bus.lsu_addr = 32'hFFFF_FFFF; bus.lsu_wdata = 32'h0000_A55A;
        go(); bus.flush_in = 1'b1; #3;
        chk1("wr_wr0", bus.mem_wr, 1'b1);
        chk("wr_a0", bus.mem_a, 32'hFFFF_FFFF);
        chk("wr_d0", 32'(bus.mem_dout), 32'h5A);
        go(); bus.flush_in = 1'b0; bus.rdy_in = 1'b0; #3;
        chk1("wr_rdy_low", bus.mem_wr, 1'b0);
        go(); bus.rdy_in = 1'b1; #3;
        chk1("wr_wr1", bus.mem_wr, 1'b1);
        chk("wr_a1", bus.mem_a, 32'h0);
        chk("wr_d1", 32'(bus.mem_dout), 32'hA5);
        go(); #3;
        chk1("wr_done", bus.lsu_done, 1'b1);
        bus.lsu_en = 1'b0; bus.lsu_wr = 1'b0;

        // reset in the middle of a fill
        go();
        bus.ic_en = 1'b1; bus.ic_addr = 32'h2000;
        go(); go(); go(); #3;
        chk1("mr_v_pre", bus.ic_valid, 1'b1);
        rst_in = 1'b1; bus.ic_en = 1'b0;
        #1;
        chk1("mr_valid", bus.ic_valid, 1'b0);
        chk("mr_byte", 32'(bus.ic_byte), 32'h0);
        chk("mr_mem_a", bus.mem_a, 32'h0);
        go(); rst_in = 1'b0;
        go(); #3;
        chk1("mr_idle_valid", bus.ic_valid, 1'b0);
        chk1("mr_idle_done", bus.ic_done, 1'b0);

        // after reset the LSU wins a tie again
        bus.ic_en = 1'b1; bus.ic_addr = 32'h2000;
        bus.lsu_en = 1'b1; bus.lsu_wr = 1'b0; bus.lsu_size = 2'd0; bus.lsu_addr = 32'h1002;
        go(); #3;
        chk("mr_tie_grant", bus.mem_a, 32'h1002);
        bus.ic_en = 1'b0;
        go(); go(); #3;
        chk1("mr_tie_done", bus.lsu_done, 1'b1);
        chk("mr_tie_rdata", bus.lsu_rdata, 32'h0000_0033);
        bus.lsu_en = 1'b0;
        go(); go();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
